// File: rtl/lab2_proc_imul_pkg.sv
// Shared types and message-field layout for the iterative integer multiplier.
// The default operand width matches the 32-bit processor datapath.
package lab2_proc_imul_pkg;

    localparam int IMUL_NBITS = 32;

    // Request message is {a, b} with a in the upper half.
    localparam int A_MSB = 2*IMUL_NBITS - 1;
    localparam int A_LSB = IMUL_NBITS;
    localparam int B_MSB = IMUL_NBITS - 1;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } imul_state_t;

endpackage

// File: rtl/lab2_proc_int_mul_iter_dpath.sv
// Datapath of the shift-add multiplier: operand shift registers and the
// wrapping result accumulator.
module lab2_proc_int_mul_iter_dpath
    import lab2_proc_imul_pkg::*;
#(
    parameter int p_nbits = IMUL_NBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [p_nbits-1:0] a_in,
    input  logic [p_nbits-1:0] b_in,
    input  logic               load,
    input  logic               calc_en,
    input  logic               add_en,
    output logic               b_lsb,
    output logic [p_nbits-1:0] result
);

    logic [p_nbits-1:0] a_reg;
    logic [p_nbits-1:0] b_reg;

    assign b_lsb = b_reg[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
        end else if (load) begin
            a_reg  <= a_in;
            b_reg  <= b_in;
            result <= '0;
        end else if (calc_en) begin
            // Sum is truncated to p_nbits, giving the low half of a*b
            // for both signed and unsigned operands.
            if (add_en) begin
                result <= result + a_reg;
            end
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
        end
    end

endmodule

// File: rtl/lab2_proc_int_mul_iter.sv
// Iterative shift-add multiplier for the MUL instruction: fixed p_nbits-cycle
// computation between a val/rdy request stream and a val/rdy response stream.
module lab2_proc_int_mul_iter
    import lab2_proc_imul_pkg::*;
#(
    parameter int p_nbits = IMUL_NBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 istream_val,
    output logic                 istream_rdy,
    input  logic [2*p_nbits-1:0] istream_msg,
    output logic                 ostream_val,
    input  logic                 ostream_rdy,
    output logic [p_nbits-1:0]   ostream_msg
);

    localparam int CW = $clog2(p_nbits) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(p_nbits - 1);

    imul_state_t        state;
    logic [CW-1:0]      count;
    logic [p_nbits-1:0] a_in;
    logic [p_nbits-1:0] b_in;
    logic               load;
    logic               calc_en;
    logic               add_en;
    logic               done;
    logic               b_lsb;

    if (p_nbits == IMUL_NBITS) begin : g_msg_default
        assign a_in = istream_msg[A_MSB:A_LSB];
        assign b_in = istream_msg[B_MSB:B_LSB];
    end else begin : g_msg_sized
        assign a_in = istream_msg[2*p_nbits-1:p_nbits];
        assign b_in = istream_msg[p_nbits-1:0];
    end

    // istream_rdy is only high in IDLE, so this is the request transfer;
    // it also keeps an X message from loading while istream_val is low.
    assign load    = istream_val && istream_rdy;
    assign calc_en = (state == CALC);
    assign add_en  = calc_en && b_lsb;
    assign done    = calc_en && (count == LAST_COUNT);

    // Handshake outputs are registered alongside the state so both are low
    // while reset is held and never depend on the input valid.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            istream_rdy <= 1'b0;
            ostream_val <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    istream_rdy <= 1'b1;
                    if (load) begin
                        state       <= CALC;
                        count       <= '0;
                        istream_rdy <= 1'b0;
                    end
                end
                CALC: begin
                    count <= count + CW'(1);
                    if (done) begin
                        state       <= DONE;
                        ostream_val <= 1'b1;
                    end
                end
                DONE: begin
                    if (ostream_rdy) begin
                        state       <= IDLE;
                        ostream_val <= 1'b0;
                        istream_rdy <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    istream_rdy <= 1'b0;
                    ostream_val <= 1'b0;
                end
            endcase
        end
    end

    lab2_proc_int_mul_iter_dpath #(
        .p_nbits (p_nbits)
    ) u_dpath (
        .clk     (clk),
        .reset   (reset),
        .a_in    (a_in),
        .b_in    (b_in),
        .load    (load),
        .calc_en (calc_en),
        .add_en  (add_en),
        .b_lsb   (b_lsb),
        .result  (ostream_msg)
    );

endmodule

// File: tb/tb_lab2_proc_int_mul_iter.sv
// Directed self-checking bench for the iterative multiplier: latency,
// wrap-around arithmetic, backpressure, back-to-back requests and async reset.
module tb_lab2_proc_int_mul_iter;

    logic        clk;
    logic        reset;
    logic        istream_val;
    logic        istream_rdy;
    logic [63:0] istream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [31:0] ostream_msg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    lab2_proc_int_mul_iter #(
        .p_nbits (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents {a,b}; returns 1 time unit after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit hold);
        int n;
        n = 0;
        istream_val = 1'b1;
        istream_msg = {a, b};
        while (!istream_rdy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_rdy", 32'(istream_rdy), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) begin
            istream_val = 1'b0;
            istream_msg = 'x;
        end
    endtask

    // Waits for ostream_val; latency counts edges from the accept edge inclusive.
    task automatic wait_resp(input string tag, input logic [31:0] expected);
        int n;
        n = 0;
        while (!ostream_val && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_val"}, 32'(ostream_val), 32'd1);
        check({tag, "_lat"}, 32'(cyc - acc_cyc + 1), 32'd33);
        check({tag, "_msg"}, ostream_msg, expected);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int prev_acc;
        bit stale;

        reset       = 1'b1;
        istream_val = 1'b0;
        istream_msg = 'x;
        ostream_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_irdy", 32'(istream_rdy), 32'd0);
        check("rst_oval", 32'(ostream_val), 32'd0);
        check("rst_omsg", ostream_msg, 32'd0);
        reset       = 1'b0;
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("idle_irdy", 32'(istream_rdy), 32'd1);
        check("idle_oval", 32'(ostream_val), 32'd0);

        // Basic product and return to IDLE after the transfer
        send(32'd3, 32'd4, 1'b0);
        check("calc_irdy", 32'(istream_rdy), 32'd0);
        wait_resp("t1", 32'd12);
        @(posedge clk);
        #1;
        check("t1_post_oval", 32'(ostream_val), 32'd0);
        check("t1_post_irdy", 32'(istream_rdy), 32'd1);

        // Signed and wrapping products
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_resp("neg1sq", 32'h0000_0001);
        send(32'h8000_0000, 32'd2, 1'b0);
        wait_resp("wrap", 32'h0000_0000);

        // Zero operands keep the fixed latency
        send(32'h1234_5678, 32'd0, 1'b0);
        wait_resp("bzero", 32'd0);
        send(32'd0, 32'hDEAD_BEEF, 1'b0);
        wait_resp("azero", 32'd0);

        // Backpressure holds the response stable
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;
        send(32'd7, 32'd6, 1'b0);
        wait_resp("bp", 32'd42);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_hold_oval", 32'(ostream_val), 32'd1);
            check("bp_hold_msg", ostream_msg, 32'd42);
            check("bp_hold_irdy", 32'(istream_rdy), 32'd0);
        end
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_oval", 32'(ostream_val), 32'd0);
        check("bp_rel_irdy", 32'(istream_rdy), 32'd1);

        // Back-to-back with istream_val held high throughout
        send(32'd5, 32'd5, 1'b1);
        wait_resp("b2b0", 32'd25);
        prev_acc = acc_cyc;
        send(32'hFFFF_FFFD, 32'd7, 1'b1);
        check("b2b1_ii", 32'(acc_cyc - prev_acc), 32'd34);
        wait_resp("b2b1", 32'hFFFF_FFEB);
        prev_acc = acc_cyc;
        send(32'h8000_0000, 32'd1, 1'b1);
        check("b2b2_ii", 32'(acc_cyc - prev_acc), 32'd34);
        istream_val = 1'b0;
        istream_msg = 'x;
        wait_resp("b2b2", 32'h8000_0000);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-CALC discards the operation
        send(32'd9, 32'd9, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_oval", 32'(ostream_val), 32'd0);
        check("arst_irdy", 32'(istream_rdy), 32'd0);
        check("arst_omsg", ostream_msg, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("arst_rel_irdy", 32'(istream_rdy), 32'd1);
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            stale = stale | ostream_val;
        end
        check("arst_no_stale", 32'(stale), 32'd0);
        send(32'd6, 32'd7, 1'b0);
        wait_resp("after_rst", 32'd42);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
